// File: rtl/sap_controller.sv
// SAP control sequencer: six-state timing ring plus INIT/HALT, decoding the
// IR opcode into the per-cycle control word for the SAP datapath.
module sap_controller #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] opcode,
  output logic [2:0] t_state,
  output logic       dp_clr,
  output logic       pc_en,
  output logic       pc_inc,
  output logic       mar_en,
  output logic       mar_ld,
  output logic       ram_en,
  output logic       ir_ld,
  output logic       ir_en,
  output logic       acc_ld,
  output logic       acc_en,
  output logic       b_ld,
  output logic       alu_en,
  output logic       sub,
  output logic       out_ld,
  output logic       halt,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  state_t state_reg;
  state_t state_next;

  always_comb begin
    state_next = S_INIT;
    case (state_reg)
      S_INIT: state_next = S_T1;
      S_T1:   state_next = S_T2;
      S_T2:   state_next = S_T3;
      S_T3:   state_next = S_T4;
      S_T4:   state_next = (opcode == OP_HLT) ? S_HALT : S_T5;
      S_T5:   state_next = S_T6;
      S_T6:   state_next = S_T1;
      S_HALT: state_next = S_HALT;
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= S_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  assign t_state = state_reg;

  // The address register only acts when mar_en is high, so every state that
  // loads, clears or reads through it raises mar_en alongside.
  always_comb begin
    dp_clr     = 1'b0;
    pc_en      = 1'b0;
    pc_inc     = 1'b0;
    mar_en     = 1'b0;
    mar_ld     = 1'b0;
    ram_en     = 1'b0;
    ir_ld      = 1'b0;
    ir_en      = 1'b0;
    acc_ld     = 1'b0;
    acc_en     = 1'b0;
    b_ld       = 1'b0;
    alu_en     = 1'b0;
    sub        = 1'b0;
    out_ld     = 1'b0;
    halt       = 1'b0;
    instr_done = 1'b0;
    case (state_reg)
      S_INIT: begin
        dp_clr = 1'b1;
        mar_en = 1'b1;
      end
      S_T1: begin
        pc_en  = 1'b1;
        mar_en = 1'b1;
        mar_ld = 1'b1;
      end
      S_T2: pc_inc = 1'b1;
      S_T3: begin
        mar_en = 1'b1;
        ram_en = 1'b1;
        ir_ld  = 1'b1;
      end
      S_T4: begin
        if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
          ir_en  = 1'b1;
          mar_en = 1'b1;
          mar_ld = 1'b1;
        end else if (opcode == OP_OUT) begin
          acc_en = 1'b1;
          out_ld = 1'b1;
        end
      end
      S_T5: begin
        if (opcode == OP_LDA) begin
          mar_en = 1'b1;
          ram_en = 1'b1;
          acc_ld = 1'b1;
        end else if (opcode == OP_ADD || opcode == OP_SUB) begin
          mar_en = 1'b1;
          ram_en = 1'b1;
          b_ld   = 1'b1;
          sub    = (opcode == OP_SUB);
        end
      end
      S_T6: begin
        instr_done = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          alu_en = 1'b1;
          acc_ld = 1'b1;
          sub    = (opcode == OP_SUB);
        end
      end
      S_HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule
